// File: rtl/pcie_s10_msi_sched.sv
// Round-robin scheduler that funnels up to 32 event sources onto the single MSI req/ack handshake.
// Optional ack timeout with retry is compiled in when PCIE_S10_MSI_TIMEOUT_EN is defined.
module pcie_s10_msi_sched #(
  parameter int         IRQ_COUNT      = 32,
  parameter logic [2:0] MSI_TC         = 3'd0,
  parameter logic [1:0] MSI_FUNC_NUM   = 2'd0,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_COUNT-1:0] irq,
  input  logic                 msi_enable,
  input  logic [2:0]           msi_mme,
  input  logic [IRQ_COUNT-1:0] msi_mask,
  output logic                 app_msi_req,
  input  logic                 app_msi_ack,
  output logic [2:0]           app_msi_tc,
  output logic [4:0]           app_msi_num,
  output logic [1:0]           app_msi_func_num,
  output logic [IRQ_COUNT-1:0] pending,
  output logic                 busy,
  output logic [15:0]          timeout_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [IRQ_COUNT-1:0] pending_q, pending_d, eligible, clr;
  logic [4:0]           ptr_q, ptr_d, sel_q, sel_d, num_q, num_d;
  logic [4:0]           pick, hi_pick, lo_pick, sel_next;
  logic                 hi_found, lo_found;
  logic                 acked, timed_out;

  if (IRQ_COUNT < 1 || IRQ_COUNT > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("pcie_s10_msi_sched: IRQ_COUNT must be 1..32 and TIMEOUT_CYCLES >= 1");
  end

  // Vectors beyond the host grant fold onto lower ones by masking the source index.
  function automatic logic [4:0] vec_mask(input logic [2:0] mme);
    return (mme >= 3'd5) ? 5'h1F : 5'((6'd1 << mme) - 6'd1);
  endfunction

  assign eligible = pending_q & ~msi_mask & {IRQ_COUNT{msi_enable}};
  assign acked    = (state_q == S_REQ) && app_msi_ack;
  assign sel_next = (sel_q == 5'(IRQ_COUNT - 1)) ? 5'd0 : sel_q + 5'd1;

  // Walking downwards leaves the lowest qualifying index in each pick; the
  // "hi" candidate covers indices at or after the pointer, "lo" the wrap-around.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    hi_pick  = '0;
    lo_pick  = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_pick  = 5'(i);
        lo_found = 1'b1;
        if (5'(i) >= ptr_q) begin
          hi_pick  = 5'(i);
          hi_found = 1'b1;
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      clr[i] = acked && (5'(i) == sel_q);
    end
    // A new pulse in the ack cycle wins over the clear, so the event is kept.
    pending_d = (pending_q & ~clr) | irq;
  end

`ifdef PCIE_S10_MSI_TIMEOUT_EN
  logic [31:0] timer_q;
  logic [15:0] to_count_q;

  assign timed_out = (state_q == S_REQ) && !app_msi_ack &&
                     (timer_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      to_count_q <= '0;
    end else begin
      timer_q <= (state_q == S_REQ) ? timer_q + 32'd1 : 32'd0;
      if (timed_out && (to_count_q != 16'hFFFF)) begin
        to_count_q <= to_count_q + 16'd1;
      end
    end
  end

  assign timeout_count = to_count_q;
`else
  assign timed_out     = 1'b0;
  assign timeout_count = 16'd0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    num_d   = num_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (lo_found) begin
          state_d = S_REQ;
          sel_d   = pick;
          num_d   = pick & vec_mask(msi_mme);
        end
      end
      S_REQ: begin
        // Enable or mask changes never abort an issued request; only ack or timeout end it.
        if (acked || timed_out) begin
          state_d = S_GAP;
          ptr_d   = sel_next;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      num_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      num_q     <= num_d;
    end
  end

  assign app_msi_req      = (state_q == S_REQ);
  assign app_msi_num      = num_q;
  assign app_msi_tc       = MSI_TC;
  assign app_msi_func_num = MSI_FUNC_NUM;
  assign pending          = pending_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_pcie_s10_msi_sched.sv
// Self-checking bench for pcie_s10_msi_sched: vector table, directed corner sequences,
// and a randomized run compared against a transaction-level model.
`timescale 1ns/1ps
module tb_pcie_s10_msi_sched;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          msi_enable;
  logic [2:0]    msi_mme;
  logic [N-1:0]  msi_mask;
  logic          app_msi_req;
  logic          app_msi_ack;
  logic [2:0]    app_msi_tc;
  logic [4:0]    app_msi_num;
  logic [1:0]    app_msi_func_num;
  logic [N-1:0]  pending;
  logic          busy;
  logic [15:0]   timeout_count;

  always #5 clk = ~clk;

  pcie_s10_msi_sched #(
    .IRQ_COUNT     (N),
    .MSI_TC        (3'd5),
    .MSI_FUNC_NUM  (2'd2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .irq             (irq),
    .msi_enable      (msi_enable),
    .msi_mme         (msi_mme),
    .msi_mask        (msi_mask),
    .app_msi_req     (app_msi_req),
    .app_msi_ack     (app_msi_ack),
    .app_msi_tc      (app_msi_tc),
    .app_msi_num     (app_msi_num),
    .app_msi_func_num(app_msi_func_num),
    .pending         (pending),
    .busy            (busy),
    .timeout_count   (timeout_count)
  );

  int tests = 0;
  int fails = 0;
  int cnt;

  // Transaction-level reference: pending set, pointer, and the one MSI in flight.
  bit [N-1:0] m_pend;
  int         m_ptr;
  int         m_inflight;
  bit         m_gap;
  int         m_num;
  int         m_hold;

  typedef struct {
    int         src;
    logic [2:0] mme;
    logic [4:0] num;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit [N-1:0] nxt;
    int j;
    if (rst) begin
      m_pend = '0; m_ptr = 0; m_inflight = -1; m_gap = 0; m_num = 0; m_hold = 0;
      return;
    end
    nxt = m_pend | irq;
    if (m_inflight >= 0) begin
      if (app_msi_ack) begin
        if (!irq[m_inflight]) nxt[m_inflight] = 1'b0;
        m_ptr      = (m_inflight + 1) % N;
        m_inflight = -1;
        m_gap      = 1;
      end else begin
        m_hold++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (msi_enable) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (m_pend[j] && !msi_mask[j]) begin
          m_inflight = j;
          m_num      = j % (1 << msi_mme);
          m_hold     = 0;
          break;
        end
      end
    end
    m_pend = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = '0; app_msi_ack = 1'b0;
    msi_enable = 1'b1; msi_mme = 3'd5; msi_mask = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input int src);
    irq = '0;
    irq[src] = 1'b1;
    tick();
    irq = '0;
  endtask

  task automatic wait_req(input string name, input int budget);
    int n;
    n = 0;
    while (!app_msi_req && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("%s req seen", name), 32'(app_msi_req), 32'd1);
  endtask

  // Wait for the request, hold it two cycles, then ack it.
  task automatic serve(input string name, input logic [4:0] exp_num);
    wait_req(name, 20);
    check($sformatf("%s num", name), 32'(app_msi_num), 32'(exp_num));
    tick(); tick();
    check($sformatf("%s held", name), 32'({app_msi_req, app_msi_num}), 32'({1'b1, exp_num}));
    app_msi_ack = 1'b1;
    tick();
    app_msi_ack = 1'b0;
    check($sformatf("%s drop", name), 32'(app_msi_req), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3, 3'd5, 5'd3};
    vecs[1] = '{13, 3'd2, 5'd1};
    vecs[2] = '{31, 3'd5, 5'd31};
    vecs[3] = '{31, 3'd3, 5'd7};
    vecs[4] = '{0, 3'd0, 5'd0};
    vecs[5] = '{17, 3'd4, 5'd1};
    vecs[6] = '{22, 3'd7, 5'd22};
    vecs[7] = '{9, 3'd1, 5'd1};
    vecs[8] = '{6, 3'd6, 5'd6};
    vecs[9] = '{18, 3'd3, 5'd2};

    do_reset();
    check("reset req", 32'(app_msi_req), 32'd0);
    check("reset num", 32'(app_msi_num), 32'd0);
    check("reset pending", pending, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset timeout_count", 32'(timeout_count), 32'd0);
    check("tc constant", 32'(app_msi_tc), 32'd5);
    check("func constant", 32'(app_msi_func_num), 32'd2);

    // Single events: pending one cycle after the pulse, req the next, clear on ack.
    for (int i = 0; i < 10; i++) begin
      msi_mme = vecs[i].mme;
      pulse(vecs[i].src);
      check($sformatf("vec%0d pending", i), pending, 32'd1 << vecs[i].src);
      check($sformatf("vec%0d req early", i), 32'(app_msi_req), 32'd0);
      tick();
      check($sformatf("vec%0d req", i), 32'(app_msi_req), 32'd1);
      check($sformatf("vec%0d num", i), 32'(app_msi_num), 32'(vecs[i].num));
      tick();
      app_msi_ack = 1'b1;
      tick();
      app_msi_ack = 1'b0;
      check($sformatf("vec%0d req after ack", i), 32'(app_msi_req), 32'd0);
      check($sformatf("vec%0d pending after ack", i), pending, 32'd0);
      check($sformatf("vec%0d busy gap", i), 32'(busy), 32'd1);
      tick();
      check($sformatf("vec%0d busy idle", i), 32'(busy), 32'd0);
    end

    // Round-robin ordering and pointer wrap.
    do_reset();
    irq = '0; irq[1] = 1'b1; irq[4] = 1'b1; irq[30] = 1'b1;
    tick();
    irq = '0;
    serve("rr1", 5'd1);
    serve("rr4", 5'd4);
    serve("rr30", 5'd30);
    irq[1] = 1'b1; irq[4] = 1'b1;
    tick();
    irq = '0;
    serve("rr1b", 5'd1);
    serve("rr4b", 5'd4);

    // Folding, masking, and collapse of repeated pulses.
    do_reset();
    msi_mme = 3'd2;
    pulse(13);
    serve("fold13", 5'd1);
    msi_mask[5] = 1'b1;
    pulse(5);
    tick();
    pulse(5);
    repeat (5) tick();
    check("masked no req", 32'(app_msi_req), 32'd0);
    check("masked pending", 32'(pending[5]), 32'd1);
    msi_mask[5] = 1'b0;
    serve("unmask5", 5'd1);
    repeat (5) tick();
    check("collapse no req", 32'(app_msi_req), 32'd0);
    check("collapse pending", pending, 32'd0);

    // Enable gating, enable drop mid-request, and a pulse in the ack cycle.
    do_reset();
    msi_enable = 1'b0;
    pulse(7);
    repeat (5) tick();
    check("disabled no req", 32'(app_msi_req), 32'd0);
    check("disabled pending", pending, 32'h80);
    msi_enable = 1'b1;
    wait_req("en7", 10);
    check("en7 num", 32'(app_msi_num), 32'd7);
    msi_enable = 1'b0;
    repeat (3) tick();
    check("enable drop holds req", 32'(app_msi_req), 32'd1);
    msi_enable = 1'b1;
    irq[7] = 1'b1; app_msi_ack = 1'b1;
    tick();
    irq = '0; app_msi_ack = 1'b0;
    check("collide req", 32'(app_msi_req), 32'd0);
    check("collide pending", 32'(pending[7]), 32'd1);
    check("collide busy", 32'(busy), 32'd1);
    tick();
    check("collide gap done", 32'({app_msi_req, busy}), 32'd0);
    tick();
    check("collide refire", 32'({app_msi_req, app_msi_num}), 32'({1'b1, 5'd7}));
    app_msi_ack = 1'b1;
    tick();
    app_msi_ack = 1'b0;
    check("collide cleared", pending, 32'd0);

    // Ack timeout behaviour.
    do_reset();
    pulse(2);
    wait_req("to", 10);
`ifdef PCIE_S10_MSI_TIMEOUT_EN
    cnt = 0;
    while (app_msi_req && cnt < 40) begin
      tick();
      cnt++;
    end
    check("timeout req cycles", cnt, 32'd16);
    check("timeout count", 32'(timeout_count), 32'd1);
    check("timeout pending kept", 32'(pending[2]), 32'd1);
    check("timeout gap busy", 32'(busy), 32'd1);
    tick(); tick();
    check("timeout retry", 32'({app_msi_req, app_msi_num}), 32'({1'b1, 5'd2}));
`else
    repeat (40) tick();
    check("no timeout req held", 32'(app_msi_req), 32'd1);
    check("no timeout count", 32'(timeout_count), 32'd0);
`endif
    app_msi_ack = 1'b1;
    tick();
    app_msi_ack = 1'b0;

    // Reset while a request is outstanding.
    do_reset();
    irq = 32'h0000_0880;
    tick();
    irq = '0;
    wait_req("rstreq", 10);
    check("rstreq num", 32'(app_msi_num), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid req", 32'(app_msi_req), 32'd0);
    check("rst mid pending", pending, 32'd0);
    check("rst mid num", 32'(app_msi_num), 32'd0);
    check("rst mid busy", 32'(busy), 32'd0);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      irq = '0;
      if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) irq[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 49) == 0) msi_mask = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 99) == 0) msi_enable = ~msi_enable;
      if ($urandom_range(0, 79) == 0) msi_mme = 3'($urandom_range(0, 7));
      app_msi_ack = (m_inflight >= 0) && (($urandom_range(0, 2) == 0) || (m_hold >= 8));
      rst = ($urandom_range(0, 999) == 0);
      tick();
      check($sformatf("rand%0d req", c), 32'(app_msi_req), 32'(m_inflight >= 0));
      check($sformatf("rand%0d busy", c), 32'(busy), 32'((m_inflight >= 0) || m_gap));
      check($sformatf("rand%0d num", c), 32'(app_msi_num), 32'(m_num));
      check($sformatf("rand%0d pending", c), pending, m_pend);
    end
    rst = 1'b0; app_msi_ack = 1'b0; irq = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcie_s10_msi_sched.md
Name: pcie_s10_msi_sched

Overview:
- Schedules interrupt requests from up to 32 internal event sources onto the single H-tile MSI handshake (app_msi_req/app_msi_ack).
- Sits between the application event logic and the PCIe hard IP MSI port.
- Latches each event as pending and picks among pending sources round-robin.
- Honours the host-granted vector count and per-vector masks, and runs one MSI transaction at a time.

Parameters:
IRQ_COUNT, 32, number of event sources (1..32)
MSI_TC, 0, traffic class driven on app_msi_tc (3 bits)
MSI_FUNC_NUM, 0, function number driven on app_msi_func_num (2 bits)
TIMEOUT_CYCLES, 4096, ack timeout (used only with the optional feature)

Ports:
clk  input  1  core clock
rst  input  1  reset
irq  input  IRQ_COUNT  per-source event pulse; 1 cycle high = 1 event
msi_enable  input  1  MSI enable bit decoded from config space
msi_mme  input  3  multiple-message-enable; granted vectors = 2**msi_mme
msi_mask  input  IRQ_COUNT  1 = source masked
app_msi_req  output  1  MSI request to hard IP
app_msi_ack  input  1  MSI acknowledge from hard IP
app_msi_tc  output  3  traffic class
app_msi_num  output  5  vector number
app_msi_func_num  output  2  function number
pending  output  IRQ_COUNT  current pending bits
busy  output  1  high in REQ or GAP state
timeout_count  output  16  ack timeouts (optional feature only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - pending=0, app_msi_req=0, app_msi_num=0, busy=0, timeout_count=0.
  - Round-robin pointer=0, state=IDLE.
  - app_msi_tc=MSI_TC and app_msi_func_num=MSI_FUNC_NUM at all times.
- Pending register:
  - pending[i] is set at the clock edge where irq[i]=1.
  - It is cleared only when source i's MSI is acked.
  - If irq[i]=1 in the same cycle as its ack, pending[i] stays 1 (the event is not lost).
  - Multiple pulses while pending collapse into one MSI.
- Eligible set: eligible[i] = pending[i] & ~msi_mask[i] & msi_enable.
- State IDLE:
  - If any source is eligible, select the first eligible index at or after the pointer, wrapping modulo IRQ_COUNT.
  - Next cycle: state=REQ, app_msi_req=1, app_msi_num = sel & (2**msi_mme - 1).
  - Vector folding: sources beyond the granted count fold onto lower vectors by this AND.
  - sel is registered and held for the whole transaction.
- State REQ:
  - app_msi_req and app_msi_num are held stable until app_msi_ack=1 is sampled.
  - On ack: next cycle app_msi_req=0, pending[sel] cleared, pointer = (sel+1) mod IRQ_COUNT, state=GAP.
- State GAP: one cycle with req=0, then IDLE. This gives at least one idle cycle between requests.
- Latency: irq pulse at cycle N → pending at N+1 → app_msi_req at N+2 (IDLE, no contention).
- Changes during an outstanding request:
  - msi_enable deasserting, or msi_mask[sel] rising, while in REQ does not abort it. The request completes on ack.
  - Masked or disabled sources keep their pending bits. They fire once unmasked or enabled.
- msi_mme changes are sampled at selection time only.
- Reset mid-transaction drops app_msi_req to 0 on the next edge. All pending bits are lost.
- busy = (state != IDLE).

Optional Feature:
- Macro: PCIE_S10_MSI_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in REQ.
  - If TIMEOUT_CYCLES elapse with no ack, app_msi_req drops and state goes to GAP.
  - pending[sel] is retained, so the request retries later.
  - The pointer still advances to sel+1.
  - timeout_count increments and saturates at 16'hFFFF.
- Disabled:
  - REQ waits for ack indefinitely.
  - timeout_count is tied to 0.
  - No counter logic is synthesised.

Test Plan:
- Single event: IRQ_COUNT=32, mme=5, enable=1; irq[3] pulse at cycle 10 → req=1 at cycle 12 with num=3; ack at cycle 15 → req=0 at cycle 16, pending[3]=0, busy=0 at cycle 17.
- Round-robin: irq[1], irq[4] and irq[30] pulse together, ack each after 2 cycles → MSIs issued in order 1, 4, 30; next irq[1]+irq[4] pair issues 1 then 4 again (pointer wraps from 31 to 0).
- Folding and mask: mme=2, irq[13] pulse → num=1. With msi_mask[5]=1, irq[5] pulse → no req and pending[5]=1; clearing the mask → req with num=1.
- Enable and collision:
  - Part 1: enable=0, pulse irq[7] → no req. Set enable=1 → req num=7.
  - Part 2: drop enable mid-REQ → req stays high until ack.
  - Part 3: irq[7] pulse in the ack cycle → second MSI num=7 follows after GAP.
- Timeout (macro on, TIMEOUT_CYCLES=16): never ack → req drops after 16 cycles, timeout_count=1, pending[sel] still 1, req reasserts after GAP.
- Reset in REQ: assert rst while req=1 → next cycle req=0, pending=0, num=0, busy=0.
